// File: rtl/enc_stream_adapter.sv
// Byte-serial framing adapter around a combinational encryptor: collect, settle, emit.
// Optional plaintext passthrough for link bring-up is enabled by defining ADAPTER_BYPASS_EN.
module enc_stream_adapter #(
  parameter int         MSG_LEN  = 8,
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic [7:0] frame_o  [MSG_LEN],
  input  logic [7:0] cipher_i [MSG_LEN],
`ifdef ADAPTER_BYPASS_EN
  input  logic       bypass_i,
`endif
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last
);

  localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] EMIT    = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [7:0]       cipher_buf [MSG_LEN];
  logic             in_fire;
  logic             out_fire;
  logic             close_frame;
  logic             load_plain;
  logic [7:0]       emit_byte;

`ifdef ADAPTER_BYPASS_EN
  assign load_plain = bypass_i;
`else
  assign load_plain = 1'b0;
`endif

  assign in_ready    = (state == COLLECT);
  assign out_valid   = (state == EMIT);
  assign in_fire     = in_ready && in_valid;
  assign out_fire    = out_valid && out_ready;
  assign close_frame = in_last || (wr_idx == LAST_IDX);

  // Select the byte being replayed; a compare-based mux keeps indexing in range for any MSG_LEN.
  always_comb begin
    emit_byte = '0;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        emit_byte = cipher_buf[i];
      end
    end
  end

  assign out_data = out_valid ? emit_byte : 8'h00;
  assign out_last = out_valid && (rd_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= COLLECT;
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_fire) begin
            if (close_frame) begin
              wr_idx <= '0;
              state  <= SETTLE;
            end else begin
              wr_idx <= wr_idx + IDX_W'(1);
            end
          end
        end
        SETTLE: begin
          state <= EMIT;
        end
        EMIT: begin
          if (out_fire) begin
            if (rd_idx == LAST_IDX) begin
              rd_idx <= '0;
              state  <= COLLECT;
            end else begin
              rd_idx <= rd_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

  // frame_o holds the plaintext image the encryptor sees; unfilled slots read as padding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        frame_o[i]    <= PAD_BYTE;
        cipher_buf[i] <= 8'h00;
      end
    end else begin
      case (state)
        COLLECT: begin
          if (in_fire) begin
            for (int i = 0; i < MSG_LEN; i++) begin
              if (IDX_W'(i) == wr_idx) begin
                frame_o[i] <= in_data;
              end else if (close_frame && (IDX_W'(i) > wr_idx)) begin
                frame_o[i] <= PAD_BYTE;
              end
            end
          end
        end
        SETTLE: begin
          for (int i = 0; i < MSG_LEN; i++) begin
            cipher_buf[i] <= load_plain ? frame_o[i] : cipher_i[i];
          end
        end
        EMIT: begin
          if (out_fire && (rd_idx == LAST_IDX)) begin
            for (int i = 0; i < MSG_LEN; i++) begin
              frame_o[i] <= PAD_BYTE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
